mitchell_mul_pipe: RTL and testbench
====================================

Name: mitchell_mul_pipe

Overview:
- Pipelined, parametrised successor to the combinational Mitchell multiplier top.
- Computes an approximate unsigned product of two N-bit operands by logarithmic approximation, with fractions truncated to L bits.
- Mode input selects plain Mitchell or minimally-biased (MBM) correction.
- Fixed 3-stage pipeline with valid/ready handshakes on both sides; sits between an operand source (FIFO/bench driver) and a result sink that may apply backpressure.

Parameters:
- N, 8, operand width in bits (N >= 4).
- L, 3, retained fraction bits after leading-one extraction (1 <= L <= N-1).
- CORR_Q, 1, MBM correction constant as an L-bit unsigned fraction (value CORR_Q/2^L), added in mode 1 only.

Ports:
- clk, input, 1, single clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand pair valid.
- in_ready, output, 1, block accepts operands this cycle.
- B1, input, N, operand A (unsigned).
- B2, input, N, operand B (unsigned).
- mode, input, 1, 0 = Mitchell, 1 = MBM; sampled with the operands.
- out_valid, output, 1, prod is valid.
- out_ready, input, 1, sink accepts prod.
- prod, output, 2N, approximate product.
- sat, output, 1, prod was saturated; qualified by out_valid.

Behaviour:
- Reset: asynchronous assert with rst_n=0 clears all stage valids. out_valid=0, prod=0, sat=0. in_ready=1 from the first cycle after deassert. In-flight operations are discarded with no partial output.
- Global stall: advance = !out_valid || out_ready. in_ready = advance.
  - Accept when in_valid && in_ready.
  - When advance=0, every stage holds data and valid.
  - Bubbles do not collapse.
- Latency: exactly 3 cycles from acceptance to out_valid with no stall. Throughput 1 result per cycle.
- S1, LOD/encode per operand:
  - k = index of the leading one, width clog2(N).
  - x = the L bits immediately below the leading one, zero-padded on the right if k < L.
  - zero flag = (operand == 0).
- S2, log add:
  - ks = k1+k2.
  - fs = x1+x2, plus CORR_Q if mode=1, held in L+2 bits.
  - zero = z1 || z2.
- S3, antilog:
  - If fs < 2^L: P = (2^L+fs) << ks >> L.
  - Else: P = fs << (ks+1) >> L.
  - Shifts are exact; the final >>L truncates (floor).
  - If zero: prod=0, sat=0.
  - If the result needs more than 2N bits: prod = 2^(2N)-1, sat=1.
- prod and sat hold stable while out_valid && !out_ready.
- in_valid may drop at any time; no combinational path from in_valid to in_ready.
- Simultaneous accept and drain in the same cycle is legal and loses no data.

Decomposition:
- Shared package mbm_pkg:
  - function clog2.
  - localparam widths K_W = clog2(N) and FS_W = L+2.
  - mode encodings MODE_MITCHELL = 0, MODE_MBM = 1.
- One sub-module: mbm_lod_enc (combinational leading-one detect plus L-bit fraction extract), instantiated twice in S1.

Test Plan:
- N=8, L=3, mode 0: B1=5, B2=14 -> prod=64, sat=0, out_valid exactly 3 cycles after accept.
- Mode 0: 7x10 -> 64; 3x3 -> 8; 255x255 -> 57344. Then mode 1, CORR_Q=1: 5x14 -> 72; 255x255 -> 61440.
- Zero operands: 0x200 -> 0; 37x0 -> 0; sat=0 in all cases.
- Backpressure: stream 5x14, 7x10, 3x3 back-to-back while holding out_ready=0 for 4 cycles after the first out_valid.
  - Required: in_ready=0 during the hold.
  - Required: prod stays 64 during the hold.
  - Required: results then emerge 64, 64, 8 in order with no loss or duplication.
- Reset mid-operation: assert rst_n=0 while 2 operations are in flight.
  - Required: out_valid=0 immediately (asynchronous).
  - Required: no stale results after release.
  - Required: the next 3x3 yields 8 at latency 3.
- Random soak: 10k random pairs with random in_valid/out_ready. Compare against a behavioural model of the S1–S3 equations. All results in order, count in = count out.

Source files
------------

// File: rtl/mbm_pkg.sv
// Shared widths, mode encodings and helpers for the pipelined Mitchell/MBM multiplier.
package mbm_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int N_DEF = 8;
    localparam int L_DEF = 3;
    localparam int K_W   = clog2(N_DEF);
    localparam int FS_W  = L_DEF + 2;

    localparam logic MODE_MITCHELL = 1'b0;
    localparam logic MODE_MBM      = 1'b1;

endpackage

// File: rtl/mbm_lod_enc.sv
// Leading-one detector plus L-bit fraction extract for one operand.
module mbm_lod_enc
    import mbm_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int L  = L_DEF,
    parameter int KW = K_W
) (
    input  logic [N-1:0]  op,
    output logic [KW-1:0] k,
    output logic [L-1:0]  x,
    output logic          zero
);

    logic [N-2:0] norm;

    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (op[i]) k = KW'(i);
        end
        // Left-justify the bits below the leading one; short operands pad with zeros.
        norm = op[N-2:0] << (KW'(N - 1) - k);
        x    = L'(norm >> (N - 1 - L));
        zero = (op == '0);
    end

endmodule

// File: rtl/mitchell_mul_pipe.sv
// Three-stage approximate unsigned multiplier (Mitchell / minimally-biased) with
// valid/ready on both sides and a single global stall.
module mitchell_mul_pipe
    import mbm_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int L      = L_DEF,
    parameter int CORR_Q = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   B1,
    input  logic [N-1:0]   B2,
    input  logic           mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] prod,
    output logic           sat
);

    localparam int STAGES = 3;
    localparam int KW     = clog2(N);
    localparam int FW     = L + 2;
    localparam int PW     = 2 * N;
    localparam int W      = FW + PW;

    logic [STAGES:1] vld_pipe;
    logic            advance;

    assign advance   = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[STAGES];

    // S1: per-operand log encode
    logic [KW-1:0] k1, k2;
    logic [L-1:0]  x1, x2;
    logic          z1, z2;

    mbm_lod_enc #(.N(N), .L(L), .KW(KW)) u_lod [1:0] (
        .op   ({B2, B1}),
        .k    ({k2, k1}),
        .x    ({x2, x1}),
        .zero ({z2, z1})
    );

    logic [KW-1:0] s1_k1, s1_k2;
    logic [L-1:0]  s1_x1, s1_x2;
    logic          s1_zero, s1_mode;

    // S2: log-domain add
    logic [KW:0]   ks_d;
    logic [FW-1:0] fs_d;

    always_comb begin
        ks_d = (KW+1)'(s1_k1) + (KW+1)'(s1_k2);
        fs_d = FW'(s1_x1) + FW'(s1_x2);
        if (s1_mode == MODE_MBM) fs_d = fs_d + FW'(CORR_Q);
    end

    logic [KW:0]   s2_ks;
    logic [FW-1:0] s2_fs;
    logic          s2_zero;

    // S3: antilog; the wide intermediate keeps every shifted-out bit for the overflow test
    logic [W-1:0]  mant, shr;
    logic [PW-1:0] prod_d;
    logic          sat_d;

    always_comb begin
        if (s2_fs < FW'(1 << L)) mant = (W'(1 << L) + W'(s2_fs)) << s2_ks;
        else                     mant = W'(s2_fs) << (s2_ks + 1'b1);
        shr    = mant >> L;
        prod_d = shr[PW-1:0];
        sat_d  = 1'b0;
        if (s2_zero) begin
            prod_d = '0;
        end else if (|shr[W-1:PW]) begin
            prod_d = '1;
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_k1    <= '0;
            s1_k2    <= '0;
            s1_x1    <= '0;
            s1_x2    <= '0;
            s1_zero  <= 1'b0;
            s1_mode  <= MODE_MITCHELL;
            s2_ks    <= '0;
            s2_fs    <= '0;
            s2_zero  <= 1'b0;
            prod     <= '0;
            sat      <= 1'b0;
        end else if (advance) begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            s1_k1    <= k1;
            s1_k2    <= k2;
            s1_x1    <= x1;
            s1_x2    <= x2;
            s1_zero  <= z1 || z2;
            s1_mode  <= mode;
            s2_ks    <= ks_d;
            s2_fs    <= fs_d;
            s2_zero  <= s1_zero;
            prod     <= prod_d;
            sat      <= sat_d;
        end
    end

endmodule

// File: tb/tb_mitchell_mul_pipe.sv
// Directed-vector bench for mitchell_mul_pipe with an in-order scoreboard and a random soak.
module tb_mitchell_mul_pipe;

    localparam int N  = 8;
    localparam int L  = 3;
    localparam int CQ = 1;

    logic         clk, rst_n;
    logic         in_valid, in_ready, mode, out_valid, out_ready, sat;
    logic [N-1:0] B1, B2;
    logic [15:0]  prod;

    // second instance with a large correction constant so saturation is reachable
    logic         rdy2, ov2, sat2;
    logic [15:0]  prod2;

    mitchell_mul_pipe #(.N(N), .L(L), .CORR_Q(CQ)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .B1(B1), .B2(B2), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .sat(sat)
    );

    mitchell_mul_pipe #(.N(N), .L(L), .CORR_Q(7)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
        .B1(B1), .B2(B2), .mode(mode), .out_valid(ov2), .out_ready(1'b1),
        .prod(prod2), .sat(sat2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, n_acc = 0, n_out = 0;
    bit chk_lat = 1'b1;
    logic [31:0] cur_exp;
    logic [31:0] exp_q[$];
    int          acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model(input int a, input int b, input int m);
        int k1, k2, x1, x2, fs, ks;
        longint p;
        if (a == 0 || b == 0) return 32'd0;
        k1 = 0; k2 = 0;
        for (int i = 0; i < N; i++) begin
            if ((a >> i) != 0) k1 = i;
            if ((b >> i) != 0) k2 = i;
        end
        x1 = ((a << L) >> k1) % (1 << L);
        x2 = ((b << L) >> k2) % (1 << L);
        fs = x1 + x2 + (m != 0 ? CQ : 0);
        ks = k1 + k2;
        if (fs < (1 << L)) p = (longint'((1 << L) + fs) << ks) >> L;
        else               p = (longint'(fs) << (ks + 1)) >> L;
        if (p > 65535) return 32'h1FFFF;
        return 32'(p);
    endfunction

    // Scoreboard: every handshake on either side is observed mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                n_out++;
                chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    logic [31:0] e;
                    int a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("prod", 32'({sat, prod}), e);
                    if (chk_lat) chk("latency", 32'(cyc - a), 32'd3);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    task automatic send(input int a, input int b, input int m, input logic [31:0] e);
        B1 = N'(a); B2 = N'(b); mode = m[0]; cur_exp = e; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("send_accept", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic sat_probe(input int a, input int b, input int m,
                             input logic [31:0] e_main, input logic [31:0] e_sat);
        send(a, b, m, e_main);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sat_ov", 32'(ov2), 32'd1);
        chk("sat_prod", 32'({sat2, prod2}), e_sat);
        @(posedge clk); #1;
    endtask

    initial begin
        int sent, guard;
        rst_n = 1'b0; in_valid = 1'b0; B1 = '0; B2 = '0; mode = 1'b0; out_ready = 1'b1;
        cur_exp = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_prod", 32'(prod), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // plain Mitchell, isolated then streamed
        send(5, 14, 0, 64);
        drain();
        send(7, 10, 0, 64);
        send(3, 3, 0, 8);
        send(255, 255, 0, 57344);
        // MBM
        send(5, 14, 1, 72);
        send(255, 255, 1, 61440);
        // zero operands
        send(0, 200, 0, 0);
        send(37, 0, 1, 0);
        drain();

        // CORR_Q=7: 5x14 -> 15<<6>>3 = 120; 255x255 -> 21<<15>>3 overflows 16 bits
        sat_probe(5, 14, 1, 72, 120);
        sat_probe(255, 255, 1, 61440, 32'h1FFFF);
        drain();

        // backpressure
        send(5, 14, 0, 64);
        send(7, 10, 0, 64);
        send(3, 3, 0, 8);
        chk_lat = 1'b0;
        out_ready = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_prod_hold", 32'(prod), 32'd64);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();
        repeat (4) @(posedge clk); #1;
        chk_lat = 1'b1;

        // reset with operations in flight
        send(5, 14, 0, 64);
        send(7, 10, 0, 64);
        send(3, 3, 0, 8);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_prod", 32'(prod), 32'd0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        chk("post_rst_idle", 32'(out_valid), 32'd0);
        send(3, 3, 0, 8);
        drain();

        // random soak with random valid/ready
        chk_lat = 1'b0;
        n_acc = 0; n_out = 0; sent = 0; guard = 0;
        while (sent < 10000 && guard < 80000) begin
            guard++;
            B1 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            B2 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            mode = 1'($urandom_range(0, 1));
            cur_exp = model(int'(B1), int'(B2), int'(mode));
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        chk("soak_sent", 32'(sent), 32'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("soak_count", 32'(n_out), 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
